// File: rtl/dl_port_sched.sv
// dl_port_sched: moves ROM-download bytes from data_io into the two SDRAM
// write ports (CPU program region on port1, GFX region on port2) using a
// toggle req/ack handshake, then releases the game core from reset once the
// whole image has been committed.
//
// Optional feature macro: DL_CHECKSUM_EN (adds dl_sum, a mod-2^16 sum of every
// byte acknowledged during the current download).
//
// Ports (all in the clk_sd domain, res_n_i asynchronous active-low):
//   ioctl_download/ioctl_wr/ioctl_addr/ioctl_dout  download stream from data_io
//   force_reset                                     OSD reset request
//   port1_req/ack, port2_req/ack                    toggle handshakes to sdram
//   port_a/port_ds/port_d/port_we                   shared write address/data
//   rom_loaded, core_reset                          load status and core reset
//   dl_err                                          sticky {timeout, overflow}
//   dl_sum (DL_CHECKSUM_EN only)                    committed byte checksum
//
// state  | meaning
// IDLE   | waiting for a FIFO entry; pops and latches address/data/route
// ISSUE  | toggles the selected port request and arms the ack timer
// WAIT   | waits for ack==req on the selected port, or abandons on timeout
module dl_port_sched #(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [22:0] GFX_BASE    = 23'h8000,
   parameter int          ACK_TIMEOUT = 255,
   parameter int          RESET_HOLD  = 16
) (
   input  logic        clk_sd,
   input  logic        res_n_i,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        force_reset,
   output logic        port1_req,
   input  logic        port1_ack,
   output logic        port2_req,
   input  logic        port2_ack,
   output logic [22:0] port_a,
   output logic [1:0]  port_ds,
   output logic [15:0] port_d,
   output logic        port_we,
   output logic        rom_loaded,
   output logic        core_reset,
   output logic [1:0]  dl_err
`ifdef DL_CHECKSUM_EN
   ,
   output logic [15:0] dl_sum
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int HW = $clog2(RESET_HOLD + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t        state;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          wr_q, dl_q, pending, sel2;
   logic [TW-1:0] timer;
   logic [HW-1:0] hold;

   logic          fifo_empty, fifo_full, wr_rise, pop, push;
   logic          dl_rise, dl_fall, ack_eq, to_gfx;
   logic [31:0]   head;
   logic [22:0]   head_word;
   logic          unused_addr;

   assign unused_addr = ioctl_addr[24];

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign wr_rise    = ioctl_wr & ~wr_q & ioctl_download;
   assign pop        = (state == S_IDLE) && !fifo_empty;
   // a pop in the same cycle frees a slot, so a push into a full FIFO is kept
   assign push       = wr_rise && (!fifo_full || pop);
   assign dl_rise    = ioctl_download & ~dl_q;
   assign dl_fall    = ~ioctl_download & dl_q;

   // entry layout: {addr[23:0], byte}; word address is addr[23:1]
   assign head      = mem[rd_ptr[AW-1:0]];
   assign head_word = head[31:9];
   assign to_gfx    = (head_word >= GFX_BASE);
   assign ack_eq    = sel2 ? (port2_ack == port2_req) : (port1_ack == port1_req);

   assign core_reset = force_reset | ~rom_loaded | (hold != '0);

   always_ff @(posedge clk_sd) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {ioctl_addr[23:0], ioctl_dout};
   end

   always_ff @(posedge clk_sd or negedge res_n_i) begin
      if (!res_n_i) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wr_q       <= 1'b0;
         dl_q       <= 1'b0;
         pending    <= 1'b0;
         sel2       <= 1'b0;
         timer      <= '0;
         hold       <= '0;
         port1_req  <= 1'b0;
         port2_req  <= 1'b0;
         port_a     <= '0;
         port_ds    <= '0;
         port_d     <= '0;
         port_we    <= 1'b0;
         rom_loaded <= 1'b0;
         dl_err     <= '0;
      end else begin
         wr_q <= ioctl_wr;
         dl_q <= ioctl_download;

         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);

         if (hold != '0) hold <= hold - HW'(1);

         if (dl_rise) begin
            rom_loaded <= 1'b0;
            dl_err     <= '0;
            pending    <= 1'b0;
         end else if (dl_fall) begin
            pending <= 1'b1;
         end else if (pending && fifo_empty && (state == S_IDLE)) begin
            rom_loaded <= 1'b1;
            pending    <= 1'b0;
            hold       <= HW'(RESET_HOLD);
         end

         if (wr_rise && fifo_full && !pop) dl_err[0] <= 1'b1;

         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  sel2    <= to_gfx;
                  port_a  <= to_gfx ? (head_word - GFX_BASE) : head_word;
                  port_ds <= {head[8], ~head[8]};
                  port_d  <= {head[7:0], head[7:0]};
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (sel2) port2_req <= ~port2_req;
               else      port1_req <= ~port1_req;
               port_we <= 1'b1;
               timer   <= TW'(ACK_TIMEOUT);
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (ack_eq) begin
                  port_we <= 1'b0;
                  state   <= S_IDLE;
               end else if (timer == '0) begin
                  // abandon: req stays toggled, the write is treated as done
                  dl_err[1] <= 1'b1;
                  port_we   <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DL_CHECKSUM_EN
   always_ff @(posedge clk_sd or negedge res_n_i) begin
      if (!res_n_i)                      dl_sum <= '0;
      else if (dl_rise)                  dl_sum <= '0;
      else if ((state == S_WAIT) && ack_eq) dl_sum <= dl_sum + 16'(port_d[7:0]);
   end
`endif

endmodule

// File: tb/tb_dl_port_sched.sv
module tb_dl_port_sched;

   logic        clk_sd = 1'b0;
   logic        res_n_i = 1'b0;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic        force_reset = 1'b0;
   logic        port1_req, port2_req;
   logic        port1_ack, port2_ack;
   logic [22:0] port_a;
   logic [1:0]  port_ds;
   logic [15:0] port_d;
   logic        port_we, rom_loaded, core_reset;
   logic [1:0]  dl_err;
`ifdef DL_CHECKSUM_EN
   logic [15:0] dl_sum;
`endif

   dl_port_sched dut (
      .clk_sd(clk_sd), .res_n_i(res_n_i),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .force_reset(force_reset),
      .port1_req(port1_req), .port1_ack(port1_ack),
      .port2_req(port2_req), .port2_ack(port2_ack),
      .port_a(port_a), .port_ds(port_ds), .port_d(port_d), .port_we(port_we),
      .rom_loaded(rom_loaded), .core_reset(core_reset), .dl_err(dl_err)
`ifdef DL_CHECKSUM_EN
      , .dl_sum(dl_sum)
`endif
   );

   always #5 clk_sd = ~clk_sd;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // sdram-side model: ack follows req with two negedges of delay unless held
   logic ack_hold = 1'b0;
   logic p1_d, p2_d;
   initial begin
      port1_ack = 1'b0; port2_ack = 1'b0; p1_d = 1'b0; p2_d = 1'b0;
      forever begin
         @(negedge clk_sd);
         if (!res_n_i) begin
            port1_ack = 1'b0; port2_ack = 1'b0; p1_d = 1'b0; p2_d = 1'b0;
         end else if (!ack_hold) begin
            port1_ack = p1_d;
            port2_ack = p2_d;
            p1_d = port1_req;
            p2_d = port2_req;
         end
      end
   end

   // toggle monitor: counts req/ack toggles and captures the bus at each request
   int t1 = 0, t2 = 0, a1 = 0, a2 = 0, last_port = 0;
   logic [22:0] last_a = '0;
   logic [1:0]  last_ds = '0;
   logic [15:0] last_d = '0;
   logic r1p = 1'b0, r2p = 1'b0, k1p = 1'b0, k2p = 1'b0;
   initial begin
      forever begin
         @(posedge clk_sd);
         #1;
         if (port1_req !== r1p) begin t1++; last_port = 1; last_a = port_a; last_ds = port_ds; last_d = port_d; end
         if (port2_req !== r2p) begin t2++; last_port = 2; last_a = port_a; last_ds = port_ds; last_d = port_d; end
         if (port1_ack !== k1p) a1++;
         if (port2_ack !== k2p) a2++;
         r1p = port1_req; r2p = port2_req; k1p = port1_ack; k2p = port2_ack;
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   typedef struct {
      logic [24:0] addr;
      logic [7:0]  data;
      int          port;
      logic [22:0] a;
      logic [1:0]  ds;
      logic [15:0] d;
   } vec_t;

   vec_t vecs[8];

   task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
      @(negedge clk_sd);
      ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      @(negedge clk_sd);
      ioctl_wr = 1'b0;
   endtask

   task automatic wait_toggle(input int b1, input int b2);
      for (int k = 0; k < 30 && t1 == b1 && t2 == b2; k++) @(negedge clk_sd);
   endtask

   task automatic wait_we_low();
      for (int k = 0; k < 400 && port_we; k++) @(negedge clk_sd);
   endtask

   task automatic wait_rom();
      for (int k = 0; k < 300 && !rom_loaded; k++) @(negedge clk_sd);
   endtask

   task automatic start_dl();
      @(negedge clk_sd); ioctl_download = 1'b1;
      @(negedge clk_sd);
   endtask

   int b1, b2, ab, cnt;

   initial begin
      vecs[0] = '{25'h0000000, 8'h11, 1, 23'h000000, 2'b01, 16'h1111};
      vecs[1] = '{25'h0000001, 8'h22, 1, 23'h000000, 2'b10, 16'h2222};
      vecs[2] = '{25'h0000002, 8'h33, 1, 23'h000001, 2'b01, 16'h3333};
      vecs[3] = '{25'h0010004, 8'hAB, 2, 23'h000002, 2'b01, 16'hABAB};
      vecs[4] = '{25'h000FFFF, 8'h5A, 1, 23'h007FFF, 2'b10, 16'h5A5A};
      vecs[5] = '{25'h0010000, 8'hC3, 2, 23'h000000, 2'b01, 16'hC3C3};
      vecs[6] = '{25'h0FFFFFF, 8'h7E, 2, 23'h7F7FFF, 2'b10, 16'h7E7E};
      vecs[7] = '{25'h1000003, 8'h96, 1, 23'h000001, 2'b10, 16'h9696};

      repeat (3) @(negedge clk_sd);
      chk("rst_req1", port1_req, 0);
      chk("rst_req2", port2_req, 0);
      chk("rst_we", port_we, 0);
      chk("rst_a", port_a, 0);
      chk("rst_rom", rom_loaded, 0);
      chk("rst_core", core_reset, 1);
      chk("rst_err", dl_err, 0);
`ifdef DL_CHECKSUM_EN
      chk("rst_sum", dl_sum, 0);
`endif
      res_n_i = 1'b1;
      repeat (2) @(negedge clk_sd);

`ifdef DL_CHECKSUM_EN
      start_dl();
      write_byte(25'h0, 8'hFF); wait_toggle(t1, t2); wait_we_low();
      b1 = t1; b2 = t2;
      write_byte(25'h1, 8'h02); wait_toggle(b1, b2); wait_we_low();
      ioctl_download = 1'b0;
      wait_rom();
      chk("sum_rom", rom_loaded, 1);
      chk("sum_val", dl_sum, 16'h0101);
`endif

      // main download: request latency, then the vector table
      start_dl();
      chk("dl_rom_low", rom_loaded, 0);
      chk("dl_core_high", core_reset, 1);
      b1 = t1;
      ioctl_addr = 25'h20; ioctl_dout = 8'h44; ioctl_wr = 1'b1;
      @(negedge clk_sd); ioctl_wr = 1'b0;
      @(negedge clk_sd);
      chk("lat_edge2", t1 - b1, 0);
      @(negedge clk_sd);
      chk("lat_edge3", t1 - b1, 1);
      wait_we_low();

      for (int i = 0; i < 8; i++) begin
         b1 = t1; b2 = t2;
         write_byte(vecs[i].addr, vecs[i].data);
         wait_toggle(b1, b2);
         chk($sformatf("v%0d_ntog", i), (t1 - b1) + (t2 - b2), 1);
         chk($sformatf("v%0d_port", i), last_port, vecs[i].port);
         chk($sformatf("v%0d_a", i), last_a, vecs[i].a);
         chk($sformatf("v%0d_ds", i), last_ds, vecs[i].ds);
         chk($sformatf("v%0d_d", i), last_d, vecs[i].d);
         chk($sformatf("v%0d_we", i), port_we, 1);
         wait_we_low();
         chk($sformatf("v%0d_we_done", i), port_we, 0);
      end

      ioctl_download = 1'b0;
      wait_rom();
      chk("load_rom", rom_loaded, 1);
      chk("load_core_hold", core_reset, 1);
      chk("load_err", dl_err, 0);
      cnt = 0;
      while (core_reset && cnt < 100) begin @(negedge clk_sd); cnt++; end
      chk("hold_cycles", cnt, 16);
      force_reset = 1'b1; #1;
      chk("force_core", core_reset, 1);
      force_reset = 1'b0; #1;
      chk("force_release", core_reset, 0);

      // download end with entries still queued
      start_dl();
      chk("q_rom_cleared", rom_loaded, 0);
      ack_hold = 1'b1;
      b1 = t1; ab = a1;
      write_byte(25'h100, 8'h01);
      write_byte(25'h101, 8'h02);
      write_byte(25'h102, 8'h03);
      ioctl_download = 1'b0;
      repeat (10) @(negedge clk_sd);
      chk("q_rom_early", rom_loaded, 0);
      chk("q_inflight", t1 - b1, 1);
      ack_hold = 1'b0;
      wait_rom();
      chk("q_rom", rom_loaded, 1);
      chk("q_acks", a1 - ab, 3);
      chk("q_reqs", t1 - b1, 3);

      // overflow: six strobes while ack is withheld
      start_dl();
      ack_hold = 1'b1;
      b1 = t1;
      for (int i = 0; i < 6; i++) write_byte(25'h200 + 25'(i), 8'(8'h60 + i));
      chk("ovf_err_now", dl_err, 2'b01);
      repeat (28) @(negedge clk_sd);
      ack_hold = 1'b0;
      ioctl_download = 1'b0;
      wait_rom();
      chk("ovf_rom", rom_loaded, 1);
      chk("ovf_reqs", t1 - b1, 5);
      chk("ovf_err", dl_err, 2'b01);

      // ack timeout
      start_dl();
      chk("to_err_cleared", dl_err, 0);
      ack_hold = 1'b1;
      b1 = t1;
      write_byte(25'h300, 8'hA1);
      wait_toggle(b1, t2);
      chk("to_first", t1 - b1, 1);
      ioctl_addr = 25'h301; ioctl_dout = 8'hA2; ioctl_wr = 1'b1;
      cnt = 0;
      while (!dl_err[1] && cnt < 400) begin
         @(negedge clk_sd); cnt++;
         if (cnt == 1) ioctl_wr = 1'b0;
      end
      chk("to_cycles", cnt, 256);
      chk("to_we", port_we, 0);
      wait_toggle(b1 + 1, t2);
      chk("to_next_issued", t1 - b1, 2);
      wait_we_low();
      ack_hold = 1'b0;
      ioctl_download = 1'b0;
      wait_rom();
      chk("to_rom", rom_loaded, 1);
      chk("to_err", dl_err, 2'b10);

      // reset while a write is outstanding
      start_dl();
      ack_hold = 1'b1;
      b1 = t1; b2 = t2;
      write_byte(25'h10008, 8'h5C);
      wait_toggle(b1, b2);
      chk("mid_port2", t2 - b2, 1);
      chk("mid_we", port_we, 1);
      res_n_i = 1'b0; #1;
      chk("mid_req1", port1_req, 0);
      chk("mid_req2", port2_req, 0);
      chk("mid_a", port_a, 0);
      chk("mid_ds", port_ds, 0);
      chk("mid_d", port_d, 0);
      chk("mid_we0", port_we, 0);
      chk("mid_rom", rom_loaded, 0);
      chk("mid_core", core_reset, 1);
      chk("mid_err", dl_err, 0);
`ifdef DL_CHECKSUM_EN
      chk("mid_sum", dl_sum, 0);
`endif
      ack_hold = 1'b0;
      ioctl_download = 1'b0;
      repeat (3) @(negedge clk_sd);
      res_n_i = 1'b1;
      repeat (2) @(negedge clk_sd);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
